// File: rtl/wac_adc_pkg.sv
// ---------------------------------------------------------------------------
// wac_adc_pkg : shared widths, frame defaults and FSM encoding for the ADC capture
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package wac_adc_pkg;

  localparam int DATA_W          = 12;
  localparam int CNT_W           = 12;
  localparam int FRAME_BITS_DFLT = 16;
  localparam int LEAD_BITS_DFLT  = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_STORE  = 3'd3;
  localparam logic [2:0] ST_QUIET  = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_sclk_tick.sv
// ---------------------------------------------------------------------------
// adc_sclk_tick : SCLK generator, low then high for CLK_DIV clk cycles per bit
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module adc_sclk_tick
  import wac_adc_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int            CW   = width_of(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          phase;
  logic          last;

  assign last = (cnt == LAST);

  // Disabled means parked at the start of a low half, so each enable opens a fresh bit.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (last) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sclk = ~en | phase;
  assign rise = en & ~phase & last;
  assign fall = en &  phase & last;

endmodule

`default_nettype wire

// File: rtl/adc_serial_capture.sv
// ---------------------------------------------------------------------------
// adc_serial_capture : burst capture from two 12-bit serial ADCs; optional ADC_LEADZERO_CHECK_EN
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module adc_serial_capture
  import wac_adc_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = FRAME_BITS_DFLT,
  parameter int LEAD_BITS  = LEAD_BITS_DFLT,
  parameter int QUIET_CYC  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              modeAdc,
  input  logic [CNT_W-1:0]  nSamples,
  input  logic              SDOADC1,
  input  logic              SDOADC2,
  output logic              CSADC1,
  output logic              CLKADC1,
  output logic              CSADC2,
  output logic              CLKADC2,
  output logic [DATA_W-1:0] dataAdc,
  output logic              readyAdc,
  output logic              busy,
  output logic              done,
  output logic              frameErr
);

  localparam int            BW         = width_of(FRAME_BITS);
  localparam int            WAIT_MAX   = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
  localparam int            WW         = width_of(WAIT_MAX);
  localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME_BITS - 1);
  localparam logic [BW-1:0] LEAD_B     = BW'(LEAD_BITS);
  localparam logic [WW-1:0] SETUP_LAST = WW'(CLK_DIV - 1);
  localparam logic [WW-1:0] QUIET_LAST = WW'((QUIET_CYC > 1) ? (QUIET_CYC - 2) : 0);

  logic [2:0]        state;
  logic              mode_q;
  logic [CNT_W-1:0]  nsamp_q;
  logic [CNT_W-1:0]  samp_cnt;
  logic [CNT_W-1:0]  samp_nxt;
  logic [WW-1:0]     wcnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] data_q;
  logic              sclk;
  logic              rise;
  logic              fall;
  logic              sdo;
  logic              cs_act;

  adc_sclk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == ST_SHIFT),
    .sclk  (sclk),
    .rise  (rise),
    .fall  (fall)
  );

  assign sdo      = mode_q ? SDOADC2 : SDOADC1;
  assign samp_nxt = samp_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mode_q   <= 1'b0;
      nsamp_q  <= '0;
      samp_cnt <= '0;
      wcnt     <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q   <= modeAdc;
            nsamp_q  <= nSamples;
            samp_cnt <= '0;
            wcnt     <= '0;
            state    <= (nSamples == '0) ? ST_FINISH : ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (wcnt == SETUP_LAST) begin
            bit_cnt <= '0;
            state   <= ST_SHIFT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (rise && (bit_cnt >= LEAD_B)) begin
            shreg <= {shreg[DATA_W-2:0], sdo};
          end
          // The last rise always precedes the final fall, so shreg is complete here.
          if (fall) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == FRAME_LAST) begin
              data_q <= shreg;
              state  <= ST_STORE;
            end
          end
        end
        ST_STORE: begin
          samp_cnt <= samp_nxt;
          wcnt     <= '0;
          if (samp_nxt == nsamp_q) begin
            state <= ST_FINISH;
          end else if (QUIET_CYC <= 1) begin
            state <= ST_SETUP;
          end else begin
            state <= ST_QUIET;
          end
        end
        ST_QUIET: begin
          if (wcnt == QUIET_LAST) begin
            wcnt  <= '0;
            state <= ST_SETUP;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign cs_act   = (state == ST_SETUP) || (state == ST_SHIFT);
  assign CSADC1   = ~(cs_act & ~mode_q);
  assign CSADC2   = ~(cs_act &  mode_q);
  assign CLKADC1  = sclk |  mode_q;
  assign CLKADC2  = sclk | ~mode_q;
  assign dataAdc  = data_q;
  assign readyAdc = (state == ST_STORE);
  assign done     = (state == ST_FINISH);
  assign busy     = (state != ST_IDLE);

`ifdef ADC_LEADZERO_CHECK_EN
  logic frame_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_err_q <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      frame_err_q <= 1'b0;
    end else if ((state == ST_SHIFT) && rise && (bit_cnt < LEAD_B) && sdo) begin
      frame_err_q <= 1'b1;
    end
  end

  assign frameErr = frame_err_q;
`else
  assign frameErr = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adc_serial_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_serial_capture : directed bench with a serial ADC model driven off SCLK falls
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_adc_serial_capture;

  localparam int CLK_DIV    = 2;
  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS  = 4;
  localparam int QUIET_CYC  = 4;
  // Latency counted inclusive of the start cycle and the strobe cycle.
  localparam int LAT_CYC    = 1 + CLK_DIV + 2 * CLK_DIV * FRAME_BITS + 1;
  localparam int PERIOD     = 1 + (QUIET_CYC - 1) + CLK_DIV + 2 * CLK_DIV * FRAME_BITS;
`ifdef ADC_LEADZERO_CHECK_EN
  localparam logic ERR_EXP  = 1'b1;
`else
  localparam logic ERR_EXP  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        modeAdc = 1'b0;
  logic [11:0] nSamples = 12'd0;
  logic        SDOADC1 = 1'b1;
  logic        SDOADC2 = 1'b1;
  logic        CSADC1, CLKADC1, CSADC2, CLKADC2;
  logic [11:0] dataAdc;
  logic        readyAdc, busy, done, frameErr;

  adc_serial_capture #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FRAME_BITS),
    .LEAD_BITS  (LEAD_BITS),
    .QUIET_CYC  (QUIET_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .modeAdc  (modeAdc),
    .nSamples (nSamples),
    .SDOADC1  (SDOADC1),
    .SDOADC2  (SDOADC2),
    .CSADC1   (CSADC1),
    .CLKADC1  (CLKADC1),
    .CSADC2   (CSADC2),
    .CLKADC2  (CLKADC2),
    .dataAdc  (dataAdc),
    .readyAdc (readyAdc),
    .busy     (busy),
    .done     (done),
    .frameErr (frameErr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model/monitor state; written only by the monitor process below.
  int          cyc = 0;
  int          widx = 0;
  int          bit_idx = 0;
  logic [15:0] cur_word = 16'h0;
  logic        pcs1 = 1'b1, pcs2 = 1'b1, pclk1 = 1'b1, pclk2 = 1'b1;
  int          rdy_cnt = 0, done_cnt = 0, done_cyc = 0;
  int          cs1_cnt = 0, cs2_cnt = 0, clk1_cnt = 0, clk2_cnt = 0;
  int          rdy_cyc [0:63];
  logic [11:0] rdy_data[0:63];

  // Frame words served by the model; written only by the test tasks.
  logic [15:0] words[0:15];

  always @(posedge clk) begin
    #1;
    cyc++;
    if ((pcs1 && !CSADC1) || (pcs2 && !CSADC2)) begin
      cur_word = words[widx % 16];
      widx++;
      bit_idx = 0;
    end
    if (!CSADC1 && pclk1 && !CLKADC1 && bit_idx < 16) begin
      SDOADC1 = cur_word[15 - bit_idx];
      bit_idx++;
    end
    if (!CSADC2 && pclk2 && !CLKADC2 && bit_idx < 16) begin
      SDOADC2 = cur_word[15 - bit_idx];
      bit_idx++;
    end
    if (readyAdc) begin
      rdy_cyc[rdy_cnt % 64]  = cyc;
      rdy_data[rdy_cnt % 64] = dataAdc;
      rdy_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!CSADC1)  cs1_cnt++;
    if (!CSADC2)  cs2_cnt++;
    if (!CLKADC1) clk1_cnt++;
    if (!CLKADC2) clk2_cnt++;
    pcs1 = CSADC1; pcs2 = CSADC2; pclk1 = CLKADC1; pclk2 = CLKADC2;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0;
    tick(3);
    vectors++; if (CSADC1 !== 1'b1)    begin miscompares++; $display("FAIL reset_cs1: got %b want 1", CSADC1); end
    vectors++; if (CSADC2 !== 1'b1)    begin miscompares++; $display("FAIL reset_cs2: got %b want 1", CSADC2); end
    vectors++; if (CLKADC1 !== 1'b1)   begin miscompares++; $display("FAIL reset_clk1: got %b want 1", CLKADC1); end
    vectors++; if (CLKADC2 !== 1'b1)   begin miscompares++; $display("FAIL reset_clk2: got %b want 1", CLKADC2); end
    vectors++; if (dataAdc !== 12'h0)  begin miscompares++; $display("FAIL reset_data: got %h want 000", dataAdc); end
    vectors++; if (readyAdc !== 1'b0)  begin miscompares++; $display("FAIL reset_ready: got %b want 0", readyAdc); end
    vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0)      begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (frameErr !== 1'b0)  begin miscompares++; $display("FAIL reset_err: got %b want 0", frameErr); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_adc1_single;
    int r0, d0, c2, k2, s, n;
    words[widx % 16] = 16'h0A5A;
    r0 = rdy_cnt; d0 = done_cnt; c2 = cs2_cnt; k2 = clk2_cnt;
    modeAdc = 1'b0; nSamples = 12'd1; start = 1'b1;
    tick(1);
    s = cyc; start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL adc1_busy_after_start: got %b want 1", busy); end
    n = 0;
    while (done_cnt == d0 && n < 400) begin tick(1); n++; end
    vectors++; if (done_cnt == d0) begin miscompares++; $display("FAIL adc1_timeout: got no done want done"); end
    vectors++; if (rdy_cnt - r0 !== 1) begin miscompares++; $display("FAIL adc1_ready_count: got %0d want 1", rdy_cnt - r0); end
    vectors++; if (rdy_data[r0 % 64] !== 12'hA5A) begin miscompares++; $display("FAIL adc1_data: got %h want a5a", rdy_data[r0 % 64]); end
    vectors++; if (rdy_cyc[r0 % 64] - s + 2 !== LAT_CYC) begin miscompares++; $display("FAIL adc1_latency: got %0d want %0d", rdy_cyc[r0 % 64] - s + 2, LAT_CYC); end
    vectors++; if (done_cyc - rdy_cyc[r0 % 64] !== 1) begin miscompares++; $display("FAIL adc1_done_gap: got %0d want 1", done_cyc - rdy_cyc[r0 % 64]); end
    vectors++; if (cs2_cnt !== c2 || clk2_cnt !== k2) begin miscompares++; $display("FAIL adc1_adc2_idle: got cs2 %0d clk2 %0d low cycles want 0", cs2_cnt - c2, clk2_cnt - k2); end
    vectors++; if (frameErr !== 1'b0) begin miscompares++; $display("FAIL adc1_err: got %b want 0", frameErr); end
    tick(1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL adc1_busy_end: got %b want 0", busy); end
    vectors++; if (dataAdc !== 12'hA5A) begin miscompares++; $display("FAIL adc1_hold: got %h want a5a", dataAdc); end
  endtask

  task automatic test_adc2_burst;
    int r0, d0, c1, s, n, b;
    b = widx;
    words[b % 16] = 16'h0001; words[(b + 1) % 16] = 16'h0FFF; words[(b + 2) % 16] = 16'h0800;
    r0 = rdy_cnt; d0 = done_cnt; c1 = cs1_cnt;
    modeAdc = 1'b1; nSamples = 12'd3; start = 1'b1;
    tick(1);
    s = cyc; start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 600) begin tick(1); n++; end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL adc2_done_count: got %0d want 1", done_cnt - d0); end
    vectors++; if (rdy_cnt - r0 !== 3) begin miscompares++; $display("FAIL adc2_ready_count: got %0d want 3", rdy_cnt - r0); end
    vectors++; if (rdy_data[r0 % 64] !== 12'h001) begin miscompares++; $display("FAIL adc2_data0: got %h want 001", rdy_data[r0 % 64]); end
    vectors++; if (rdy_data[(r0 + 1) % 64] !== 12'hFFF) begin miscompares++; $display("FAIL adc2_data1: got %h want fff", rdy_data[(r0 + 1) % 64]); end
    vectors++; if (rdy_data[(r0 + 2) % 64] !== 12'h800) begin miscompares++; $display("FAIL adc2_data2: got %h want 800", rdy_data[(r0 + 2) % 64]); end
    vectors++; if (rdy_cyc[r0 % 64] - s + 2 !== LAT_CYC) begin miscompares++; $display("FAIL adc2_latency: got %0d want %0d", rdy_cyc[r0 % 64] - s + 2, LAT_CYC); end
    vectors++; if (rdy_cyc[(r0 + 1) % 64] - rdy_cyc[r0 % 64] !== PERIOD) begin miscompares++; $display("FAIL adc2_period01: got %0d want %0d", rdy_cyc[(r0 + 1) % 64] - rdy_cyc[r0 % 64], PERIOD); end
    vectors++; if (rdy_cyc[(r0 + 2) % 64] - rdy_cyc[(r0 + 1) % 64] !== PERIOD) begin miscompares++; $display("FAIL adc2_period12: got %0d want %0d", rdy_cyc[(r0 + 2) % 64] - rdy_cyc[(r0 + 1) % 64], PERIOD); end
    vectors++; if (cs1_cnt !== c1) begin miscompares++; $display("FAIL adc2_cs1_idle: got %0d low cycles want 0", cs1_cnt - c1); end
    tick(2);
  endtask

  task automatic test_nsamples_zero;
    int r0, d0, c1, c2, s;
    r0 = rdy_cnt; d0 = done_cnt; c1 = cs1_cnt; c2 = cs2_cnt;
    modeAdc = 1'b0; nSamples = 12'd0; start = 1'b1;
    tick(1);
    s = cyc; start = 1'b0;
    tick(3);
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); end
    vectors++; if (done_cyc - s + 2 !== 2) begin miscompares++; $display("FAIL zero_done_latency: got %0d want 2", done_cyc - s + 2); end
    vectors++; if (rdy_cnt !== r0) begin miscompares++; $display("FAIL zero_ready: got %0d strobes want 0", rdy_cnt - r0); end
    vectors++; if (cs1_cnt !== c1 || cs2_cnt !== c2) begin miscompares++; $display("FAIL zero_cs: got %0d/%0d low cycles want 0", cs1_cnt - c1, cs2_cnt - c2); end
    vectors++; if (dataAdc !== 12'h800) begin miscompares++; $display("FAIL zero_hold: got %h want 800", dataAdc); end
  endtask

  task automatic test_reset_midframe;
    int r0, d0, n, b;
    b = widx;
    words[b % 16] = 16'h0FFF; words[(b + 1) % 16] = 16'h0C3C;
    r0 = rdy_cnt;
    modeAdc = 1'b0; nSamples = 12'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (!(CSADC1 == 1'b0 && bit_idx >= 8) && n < 200) begin tick(1); n++; end
    vectors++; if (bit_idx < 8) begin miscompares++; $display("FAIL midrst_timeout: got bit %0d want 8", bit_idx); end
    rst_n = 1'b0;
    tick(1);
    vectors++; if (CSADC1 !== 1'b1)   begin miscompares++; $display("FAIL midrst_cs1: got %b want 1", CSADC1); end
    vectors++; if (CLKADC1 !== 1'b1)  begin miscompares++; $display("FAIL midrst_clk1: got %b want 1", CLKADC1); end
    vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
    vectors++; if (readyAdc !== 1'b0) begin miscompares++; $display("FAIL midrst_ready: got %b want 0", readyAdc); end
    rst_n = 1'b1;
    tick(2);
    vectors++; if (rdy_cnt !== r0) begin miscompares++; $display("FAIL midrst_no_strobe: got %0d strobes want 0", rdy_cnt - r0); end
    d0 = done_cnt;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 400) begin tick(1); n++; end
    vectors++; if (rdy_cnt - r0 !== 1) begin miscompares++; $display("FAIL midrst_recover_count: got %0d want 1", rdy_cnt - r0); end
    vectors++; if (rdy_data[r0 % 64] !== 12'hC3C) begin miscompares++; $display("FAIL midrst_recover_data: got %h want c3c", rdy_data[r0 % 64]); end
    tick(2);
  endtask

  task automatic test_start_while_busy;
    int r0, d0, c1, c2, n, b;
    b = widx;
    words[b % 16] = 16'h0123; words[(b + 1) % 16] = 16'h0456;
    words[(b + 2) % 16] = 16'h0FFF; words[(b + 3) % 16] = 16'h0FFF;
    r0 = rdy_cnt; d0 = done_cnt; c2 = cs2_cnt;
    modeAdc = 1'b0; nSamples = 12'd2; start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (!(CSADC1 == 1'b0 && bit_idx >= 3) && n < 200) begin tick(1); n++; end
    modeAdc = 1'b1; nSamples = 12'd5; start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 800) begin tick(1); n++; end
    vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL busy_done_count: got %0d want 1", done_cnt - d0); end
    vectors++; if (rdy_cnt - r0 !== 2) begin miscompares++; $display("FAIL busy_ready_count: got %0d want 2", rdy_cnt - r0); end
    vectors++; if (rdy_data[r0 % 64] !== 12'h123) begin miscompares++; $display("FAIL busy_data0: got %h want 123", rdy_data[r0 % 64]); end
    vectors++; if (rdy_data[(r0 + 1) % 64] !== 12'h456) begin miscompares++; $display("FAIL busy_data1: got %h want 456", rdy_data[(r0 + 1) % 64]); end
    vectors++; if (cs2_cnt !== c2) begin miscompares++; $display("FAIL busy_cs2_idle: got %0d low cycles want 0", cs2_cnt - c2); end
    // Now in the FINISH cycle: a start here must be ignored.
    c1 = cs1_cnt; c2 = cs2_cnt;
    modeAdc = 1'b0; nSamples = 12'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL finish_start_busy: got %b want 0", busy); end
    tick(6);
    vectors++; if (cs1_cnt !== c1 || cs2_cnt !== c2) begin miscompares++; $display("FAIL finish_start_cs: got %0d/%0d low cycles want 0", cs1_cnt - c1, cs2_cnt - c2); end
  endtask

  task automatic test_leadzero;
    int r0, d0, n;
    words[widx % 16] = 16'h2123;
    r0 = rdy_cnt; d0 = done_cnt;
    modeAdc = 1'b0; nSamples = 12'd1; start = 1'b1;
    tick(1);
    start = 1'b0;
    n = 0;
    while (!(CSADC1 == 1'b0 && bit_idx >= 4) && n < 200) begin tick(1); n++; end
    vectors++; if (frameErr !== ERR_EXP) begin miscompares++; $display("FAIL lead_err_set: got %b want %b", frameErr, ERR_EXP); end
    n = 0;
    while (done_cnt == d0 && n < 400) begin tick(1); n++; end
    vectors++; if (rdy_cnt - r0 !== 1) begin miscompares++; $display("FAIL lead_ready_count: got %0d want 1", rdy_cnt - r0); end
    vectors++; if (rdy_data[r0 % 64] !== 12'h123) begin miscompares++; $display("FAIL lead_data: got %h want 123", rdy_data[r0 % 64]); end
    tick(3);
    vectors++; if (frameErr !== ERR_EXP) begin miscompares++; $display("FAIL lead_err_sticky: got %b want %b", frameErr, ERR_EXP); end
    nSamples = 12'd0; start = 1'b1;
    tick(1);
    start = 1'b0;
    vectors++; if (frameErr !== 1'b0) begin miscompares++; $display("FAIL lead_err_clear: got %b want 0", frameErr); end
    tick(2);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) words[i] = 16'h0000;
    test_reset;
    test_adc1_single;
    test_adc2_burst;
    test_nsamples_zero;
    test_reset_midframe;
    test_start_while_busy;
    test_leadzero;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
